// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, prefetch FIFO
// feeding decode, redirect flush with discard of in-flight responses.
module ifetch_unit #(
   parameter int                 I_WIDTH    = 32,
   parameter int                 A_WIDTH    = 32,
   parameter logic [A_WIDTH-1:0] RESET_PC   = '0,
   parameter int                 FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [A_WIDTH-1:0] imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [I_WIDTH-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [A_WIDTH-1:0] redirect_pc,
   input  logic               stall,
   output logic [I_WIDTH-1:0] instruction,
   output logic [A_WIDTH-1:0] pc_out,
   output logic               go,
   output logic               fetch_err
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {INIT, RUN, DRAIN} state_e;

   state_e             state_q, state_d;
   logic [A_WIDTH-1:0] pc_q, pc_d;
   logic [CW-1:0]      out_q, out_d;    // granted, response pending, still wanted
   logic [CW-1:0]      disc_q, disc_d;  // granted before a redirect, to be dropped
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [PW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
   logic               err_q, err_d;
   logic [I_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
   logic [A_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];

   logic [CW-1:0]      inflight;
   logic               grant, rv_ok, push, empty;
   logic [A_WIDTH-1:0] rsp_pc;

   // Handshake decode: credit, grant, response acceptance, pop
   always_comb begin
      inflight  = out_q + disc_q;
      imem_req  = (state_q == RUN) && (({1'b0, cnt_q} + {1'b0, out_q}) < DEPTH_W);
      imem_addr = pc_q;
      grant     = imem_req & imem_gnt;
      rv_ok     = imem_rvalid & (inflight != '0);
      push      = rv_ok & ~redirect_valid & (disc_q == '0);
      empty     = (cnt_q == '0);
      go        = ~empty & ~stall & ~redirect_valid & (state_q == RUN);
      // Requests are issued to consecutive words, so the oldest pending one
      // sits out_q words behind the current PC.
      rsp_pc      = pc_q - (A_WIDTH'(out_q) << 2);
      instruction = empty ? '0 : fifo_data_q[rptr_q];
      pc_out      = empty ? '0 : fifo_pc_q[rptr_q];
      fetch_err   = err_q;
   end

   // Next state for FSM, PC, counters and FIFO pointers
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      out_d   = out_q;
      disc_d  = disc_q;
      cnt_d   = cnt_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      err_d   = err_q | (imem_rvalid & (inflight == '0));
      if (state_q == INIT) state_d = RUN;
      if (grant) pc_d = pc_q + A_WIDTH'(4);
      if (redirect_valid) begin
         // Everything still in flight becomes garbage; FIFO is flushed.
         pc_d    = {redirect_pc[A_WIDTH-1:2], 2'b00};
         out_d   = '0;
         disc_d  = inflight + CW'(grant) - CW'(rv_ok);
         state_d = (disc_d != '0) ? DRAIN : RUN;
         cnt_d   = '0;
         wptr_d  = '0;
         rptr_d  = '0;
      end else begin
         if (disc_q != '0) begin
            disc_d = disc_q - CW'(rv_ok);
            if (disc_d == '0) state_d = RUN;
         end else begin
            out_d = out_q + CW'(grant) - CW'(rv_ok);
         end
         if (push) wptr_d = wptr_q + PW'(1);
         if (go)   rptr_d = rptr_q + PW'(1);
         cnt_d = cnt_q + CW'(push) - CW'(go);
      end
   end

   // Control state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
         pc_q    <= RESET_PC;
         out_q   <= '0;
         disc_q  <= '0;
         cnt_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         out_q   <= out_d;
         disc_q  <= disc_d;
         cnt_q   <= cnt_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         err_q   <= err_d;
      end
   end

   // FIFO storage; contents are masked by the count so need no reset
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_q[wptr_q] <= imem_rdata;
         fifo_pc_q[wptr_q]   <= rsp_pc;
      end
   end
endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit: in-order memory model plus a scoreboard
// of expected instruction stream, credit and redirect/discard behaviour.
module tb_ifetch_unit;
   localparam int DEPTH = 2;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        imem_req, imem_gnt, imem_rvalid, redirect_valid, stall;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, instruction, pc_out;
   logic        go, fetch_err;

   ifetch_unit #(.I_WIDTH(32), .A_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
      .instruction(instruction), .pc_out(pc_out), .go(go), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          ready;
      bit          stale;
   } mreq_t;

   mreq_t       memq[$];   // requests granted by memory, awaiting response
   logic [31:0] mfifo[$];  // PCs of instructions buffered for decode
   logic [31:0] fpc;       // next fetch address
   int cyc = 0, last_ready = 0, since_rst = 0, lat_max = 0;
   int total = 0, bad = 0, first_go = -1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      memq.delete(); mfifo.delete(); fpc = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_go", go, 0);
      chk("rst_instr", instruction, 0);
      chk("rst_pc", pc_out, 0);
      chk("rst_err", fetch_err, 0);
      rst_n = 1'b1;
      since_rst = 0;
      last_ready = cyc;
      first_go = -1;
   endtask

   // One cycle, entered and left at the falling edge.
   task automatic step(input bit st, input bit rd, input logic [31:0] rp, input bit gn);
      bit v, exp_req, exp_go, g;
      int stale, rdy;
      mreq_t e;
      stall = st; redirect_valid = rd; redirect_pc = rp; imem_gnt = gn;
      v = (memq.size() > 0) && (memq[0].ready <= cyc);
      imem_rvalid = v;
      imem_rdata  = v ? mem_word(memq[0].addr) : $urandom;
      #1;
      stale = 0;
      foreach (memq[i]) if (memq[i].stale) stale++;
      exp_req = (since_rst > 0) && (stale == 0) && (mfifo.size() + memq.size() < DEPTH);
      exp_go  = (mfifo.size() > 0) && !st && !rd && (stale == 0);
      chk("req", imem_req, exp_req);
      chk("addr", imem_addr, fpc);
      chk("go", go, exp_go);
      chk("pc_out", pc_out, mfifo.size() > 0 ? mfifo[0] : 32'h0);
      chk("instr", instruction, mfifo.size() > 0 ? mem_word(mfifo[0]) : 32'h0);
      if (go && first_go < 0) first_go = since_rst;
      g = exp_req && gn;
      rdy = cyc + 1 + $urandom_range(0, lat_max);
      if (rdy <= last_ready) rdy = last_ready + 1;
      if (v) e = memq.pop_front();
      if (rd) begin
         mfifo.delete();
         foreach (memq[i]) memq[i].stale = 1'b1;
         if (g) begin memq.push_back(mreq_t'{addr: fpc, ready: rdy, stale: 1'b1}); last_ready = rdy; end
         fpc = rp & ~32'h3;
      end else begin
         if (v && !e.stale) mfifo.push_back(e.addr);
         if (exp_go) void'(mfifo.pop_front());
         if (g) begin
            memq.push_back(mreq_t'{addr: fpc, ready: rdy, stale: 1'b0});
            last_ready = rdy;
            fpc = fpc + 32'd4;
         end
      end
      @(posedge clk);
      cyc++; since_rst++;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] rp;
      bit          st, rd, gn;
      int          stall_run;

      // Streaming: always granted, one-cycle latency
      do_reset();
      lat_max = 0;
      repeat (12) step(0, 0, 0, 1);
      chk("first_go_lat", first_go, 3);
      // Full FIFO held by stall, then released
      repeat (6) step(1, 0, 0, 1);
      repeat (6) step(0, 0, 0, 1);
      // Redirect while requests in flight, low bits forced to zero
      step(0, 1, 32'h0000_0103, 1);
      repeat (8) step(0, 0, 0, 1);
      // Address wrap at the top of the space
      step(0, 1, 32'hFFFF_FFFE, 1);
      repeat (8) step(0, 0, 0, 1);

      // Mid-run reset, then random traffic
      do_reset();
      lat_max = 2;
      stall_run = 0;
      repeat (3000) begin
         if (stall_run > 0) begin st = 1; stall_run--; end
         else begin
            st = ($urandom_range(0, 9) < 2);
            if ($urandom_range(0, 40) == 0) stall_run = 6;
         end
         rd = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 2))
            0:       rp = $urandom;
            1:       rp = 32'h0000_0103;
            default: rp = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         endcase
         gn = ($urandom_range(0, 9) < 7);
         step(st, rd, rp, gn);
      end

      // Spurious response with nothing in flight
      repeat (10) step(1, 0, 0, 0);
      chk("err_before", fetch_err, 0);
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; stall = 1'b0;
      #1;
      chk("err_go", go, mfifo.size() > 0);
      @(posedge clk);
      @(negedge clk);
      imem_rvalid = 1'b0;
      chk("err_set", fetch_err, 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("err_sticky", fetch_err, 1);
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
